i2c_txn_scheduler: RTL and testbench

//  Shares one byte-level I2C engine between N_REQ requesters. Round-robin arbitration

---
 rtl/i2c_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 39 +++
 rtl/i2c_txn_scheduler.sv | 196 +++++++++++++++++++
 tb/tb_i2c_txn_scheduler.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C transaction scheduler: FSM state encoding and
// the R/W bit that follows the 7-bit slave address on the wire.
package i2c_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_ADDR,
    S_DATA,
    S_STOP,
    S_DONE
  } state_t;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer,
// wrapping; the pointer moves one past the winner when the owner advances.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] ptr;

  // NOTE: every output gets a default before the search so no latch is inferred.
  // Scanning from the farthest offset down lets the nearest requester win last.
  always_comb begin
    grant = '0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[(int'(ptr) + i) % N]) begin
        grant                      = '0;
        grant[(int'(ptr) + i) % N] = 1'b1;
        idx                        = IW'((int'(ptr) + i) % N);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (advance && |req) begin
      ptr <= (int'(idx) == N - 1) ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/i2c_txn_scheduler.sv
// Shares one byte-level I2C engine between N_REQ requesters, sequencing
// START / address / data / STOP commands for the round-robin winner.
module i2c_txn_scheduler
  import i2c_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 4096,
  parameter int TO_W    = 13
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [7*N_REQ-1:0] req_addr,
  input  logic [N_REQ-1:0]   req_rw,
  input  logic [4*N_REQ-1:0] req_len,
  input  logic [8*N_REQ-1:0] req_wdata,
  output logic [N_REQ-1:0]   req_wack,
  output logic [7:0]         req_rdata,
  output logic [N_REQ-1:0]   req_rvalid,
  output logic [N_REQ-1:0]   req_done,
  output logic [N_REQ-1:0]   req_nack,
  output logic [N_REQ-1:0]   req_timeout,
  output logic [N_REQ-1:0]   grant,
  output logic               eng_start,
  output logic               eng_write,
  output logic               eng_read,
  output logic               eng_stop,
  output logic [7:0]         eng_wdata,
  output logic               eng_mack,
  input  logic               eng_done,
  input  logic [7:0]         eng_rdata,
  input  logic               eng_ack
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_t          state;
  logic [IW-1:0]   g_idx;
  logic [6:0]      addr;
  logic            rw;
  logic [3:0]      len;
  logic [3:0]      cnt;
  logic [TO_W-1:0] to_cnt;
  logic            nack_f;
  logic            to_f;

  logic [N_REQ-1:0] arb_grant;
  logic [IW-1:0]    arb_idx;
  logic             arb_advance;
  logic             expired;
  logic             last_byte;
  logic             issue_data;
  logic [3:0]       issue_idx;

  assign arb_advance = (state == S_IDLE);

  rr_arbiter #(.N(N_REQ), .IW(IW)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (req_valid),
    .advance (arb_advance),
    .grant   (arb_grant),
    .idx     (arb_idx)
  );

  assign expired   = (to_cnt == TO_W'(TIMEOUT - 1));
  assign last_byte = (cnt + 4'd1 == len);
  assign issue_idx = (state == S_ADDR) ? 4'd0 : cnt + 4'd1;

  // A data command goes out on the same edge that retires the previous one.
  assign issue_data = eng_done &&
    ((state == S_ADDR && eng_ack && len != 4'd0) ||
     (state == S_DATA && !(rw == RW_WRITE && !eng_ack) && !last_byte));

  // NOTE: sequential state uses non-blocking assignments only, so every branch
  // below sees the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      g_idx       <= '0;
      addr        <= '0;
      rw          <= RW_WRITE;
      len         <= '0;
      cnt         <= '0;
      to_cnt      <= '0;
      nack_f      <= 1'b0;
      to_f        <= 1'b0;
      grant       <= '0;
      req_wack    <= '0;
      req_rdata   <= '0;
      req_rvalid  <= '0;
      req_done    <= '0;
      req_nack    <= '0;
      req_timeout <= '0;
      eng_start   <= 1'b0;
      eng_write   <= 1'b0;
      eng_read    <= 1'b0;
      eng_stop    <= 1'b0;
      eng_wdata   <= '0;
      eng_mack    <= 1'b0;
    end else begin
      eng_start   <= 1'b0;
      eng_write   <= 1'b0;
      eng_read    <= 1'b0;
      eng_stop    <= 1'b0;
      eng_mack    <= 1'b0;
      req_wack    <= '0;
      req_rvalid  <= '0;
      req_done    <= '0;
      req_nack    <= '0;
      req_timeout <= '0;
      to_cnt      <= to_cnt + 1'b1;

      case (state)
        S_IDLE: begin
          to_cnt <= '0;
          if (|req_valid) begin
            grant     <= arb_grant;
            g_idx     <= arb_idx;
            addr      <= req_addr[int'(arb_idx)*7 +: 7];
            rw        <= req_rw[arb_idx];
            len       <= req_len[int'(arb_idx)*4 +: 4];
            cnt       <= '0;
            nack_f    <= 1'b0;
            to_f      <= 1'b0;
            eng_start <= 1'b1;
            state     <= S_START;
          end
        end
        S_START, S_ADDR, S_DATA: begin
          if (eng_done) begin
            if (state == S_START) begin
              eng_write <= 1'b1;
              eng_wdata <= {addr, rw};
              to_cnt    <= '0;
              state     <= S_ADDR;
            end else begin
              if (state == S_DATA) begin
                cnt <= cnt + 4'd1;
                if (rw == RW_READ) begin
                  req_rdata          <= eng_rdata;
                  req_rvalid[g_idx]  <= 1'b1;
                end
              end
              if ((state == S_ADDR || rw == RW_WRITE) && !eng_ack) begin
                nack_f   <= 1'b1;
                eng_stop <= 1'b1;
                to_cnt   <= '0;
                state    <= S_STOP;
              end else if ((state == S_ADDR && len == 4'd0) ||
                           (state == S_DATA && last_byte)) begin
                eng_stop <= 1'b1;
                to_cnt   <= '0;
                state    <= S_STOP;
              end else begin
                state <= S_DATA;
              end
            end
          end else if (expired) begin
            to_f     <= 1'b1;
            eng_stop <= 1'b1;
            to_cnt   <= '0;
            state    <= S_STOP;
          end
        end
        S_STOP: begin
          // A STOP that never completes still releases the requester.
          if (eng_done || expired) begin
            req_done[g_idx]    <= 1'b1;
            req_nack[g_idx]    <= nack_f;
            req_timeout[g_idx] <= to_f | ~eng_done;
            state              <= S_DONE;
          end
        end
        S_DONE: begin
          grant <= '0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      if (issue_data) begin
        to_cnt <= '0;
        if (rw == RW_WRITE) begin
          eng_write       <= 1'b1;
          eng_wdata       <= req_wdata[int'(g_idx)*8 +: 8];
          req_wack[g_idx] <= 1'b1;
        end else begin
          eng_read <= 1'b1;
          eng_mack <= (issue_idx != len - 4'd1);
        end
      end
    end
  end

endmodule

// File: tb/tb_i2c_txn_scheduler.sv
// Directed bench for i2c_txn_scheduler: a small engine model answers commands
// and the checks compare command streams and requester pulses against constants.
module tb_i2c_txn_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [27:0] req_addr;
  logic [3:0]  req_rw;
  logic [15:0] req_len;
  logic [31:0] req_wdata;
  logic [3:0]  req_wack;
  logic [7:0]  req_rdata;
  logic [3:0]  req_rvalid;
  logic [3:0]  req_done;
  logic [3:0]  req_nack;
  logic [3:0]  req_timeout;
  logic [3:0]  grant;
  logic        eng_start, eng_write, eng_read, eng_stop;
  logic [7:0]  eng_wdata;
  logic        eng_mack;
  logic        eng_done;
  logic [7:0]  eng_rdata;
  logic        eng_ack;
  logic [44:0] outs;

  always #5 clk = ~clk;

  i2c_txn_scheduler #(.N_REQ(4), .TIMEOUT(16), .TO_W(5)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_addr    (req_addr),
    .req_rw      (req_rw),
    .req_len     (req_len),
    .req_wdata   (req_wdata),
    .req_wack    (req_wack),
    .req_rdata   (req_rdata),
    .req_rvalid  (req_rvalid),
    .req_done    (req_done),
    .req_nack    (req_nack),
    .req_timeout (req_timeout),
    .grant       (grant),
    .eng_start   (eng_start),
    .eng_write   (eng_write),
    .eng_read    (eng_read),
    .eng_stop    (eng_stop),
    .eng_wdata   (eng_wdata),
    .eng_mack    (eng_mack),
    .eng_done    (eng_done),
    .eng_rdata   (eng_rdata),
    .eng_ack     (eng_ack)
  );

  assign outs = {req_wack, req_rdata, req_rvalid, req_done, req_nack, req_timeout,
                 grant, eng_start, eng_write, eng_read, eng_stop, eng_wdata, eng_mack};

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  logic [11:0] log_q[$];
  int          log_cyc[$];
  logic [11:0] exp_q[$];
  logic [7:0]  rd_q[$];
  logic [7:0]  rv_q[$];
  int          rv_who[$];
  int          eng_wait = 0;
  logic        pend_ack;
  logic [7:0]  pend_rdata;
  bit          nack_addr = 0, first_wr = 0, mute_start = 0, rearm0 = 0;
  logic [7:0]  wbytes[4][16];
  int          wptr[4];
  int          wack_cnt[4];
  int          done_cnt;
  logic [3:0]  last_done, last_nack, last_to;
  logic [3:0]  prev_grant = '0;
  int          grant_seq, grant_n;
  int          multi_cnt = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int onehot_idx(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return 15;
  endfunction

  // One clock: engine model, requester-side bookkeeping, grant tracking.
  task automatic tick();
    @(negedge clk);
    cyc++;
    eng_done = 1'b0;
    if (eng_wait > 0) begin
      eng_wait--;
      if (eng_wait == 0) begin
        eng_done  = 1'b1;
        eng_ack   = pend_ack;
        eng_rdata = pend_rdata;
      end
    end
    if (eng_start || eng_write || eng_read || eng_stop) begin
      log_cyc.push_back(cyc);
      eng_wait   = 2;
      pend_ack   = 1'b1;
      pend_rdata = 8'h00;
      if (eng_start) begin
        log_q.push_back({4'd1, 8'h00});
        first_wr = 1;
        if (mute_start) eng_wait = 0;
      end else if (eng_write) begin
        log_q.push_back({4'd2, eng_wdata});
        pend_ack = !(nack_addr && first_wr);
        first_wr = 0;
      end else if (eng_read) begin
        log_q.push_back({4'd3, 7'd0, eng_mack});
        if (rd_q.size() > 0) pend_rdata = rd_q.pop_front();
      end else begin
        log_q.push_back({4'd4, 8'h00});
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (req_wack[i]) begin
        wack_cnt[i]++;
        wptr[i]++;
        req_wdata[i*8 +: 8] = wbytes[i][wptr[i] % 16];
      end
      if (req_rvalid[i]) begin
        rv_q.push_back(req_rdata);
        rv_who.push_back(i);
      end
      if (req_done[i]) begin
        done_cnt++;
        last_done = req_done;
        last_nack = req_nack;
        last_to   = req_timeout;
        if (i == 0 && rearm0) begin
          rearm0          = 0;
          wptr[0]         = 0;
          req_wdata[7:0]  = wbytes[0][0];
        end else begin
          req_valid[i] = 1'b0;
        end
      end
    end
    if (grant != 4'd0 && prev_grant == 4'd0) begin
      grant_seq = (grant_seq << 4) | onehot_idx(grant);
      grant_n++;
    end
    if (grant != 4'd0 && !$onehot(grant)) multi_cnt++;
    prev_grant = grant;
  endtask

  task automatic new_txn();
    log_q.delete(); log_cyc.delete(); rv_q.delete(); rv_who.delete();
    for (int i = 0; i < 4; i++) wack_cnt[i] = 0;
    done_cnt  = 0;
    grant_seq = 0;
    grant_n   = 0;
    last_done = '0; last_nack = '0; last_to = '0;
  endtask

  task automatic arm(input int i, input logic [6:0] a, input logic rw, input logic [3:0] len);
    req_addr[i*7 +: 7]  = a;
    req_rw[i]           = rw;
    req_len[i*4 +: 4]   = len;
    wptr[i]             = 0;
    req_wdata[i*8 +: 8] = wbytes[i][0];
  endtask

  task automatic wait_done(input string tag, input int n);
    int k;
    k = 0;
    while (done_cnt < n && k < 400) begin
      tick();
      k++;
    end
    check({tag, "_bound"}, 64'(done_cnt >= n), 64'd1);
    tick();
    tick();
  endtask

  task automatic check_log(input string tag);
    check({tag, "_ncmd"}, 64'(log_q.size()), 64'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && k < log_q.size(); k++)
      check($sformatf("%s_cmd%0d", tag, k), 64'(log_q[k]), 64'(exp_q[k]));
  endtask

  initial begin
    reset = 1'b1; req_valid = '0; req_addr = '0; req_rw = '0; req_len = '0;
    req_wdata = '0; eng_done = 1'b0; eng_rdata = '0; eng_ack = 1'b0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 16; j++) wbytes[i][j] = 8'(16 * i + j + 1);
    wbytes[0][0] = 8'hA5;
    wbytes[0][1] = 8'h3C;
    repeat (3) tick();
    check("reset_outs", 64'(outs), 64'd0);
    reset = 1'b0;
    tick();

    // single write
    new_txn();
    arm(0, 7'h50, 1'b0, 4'd2);
    req_valid[0] = 1'b1;
    wait_done("wr", 1);
    exp_q = '{12'h100, 12'h2A0, 12'h2A5, 12'h23C, 12'h400};
    check_log("wr");
    check("wr_wack", 64'(wack_cnt[0]), 64'd2);
    check("wr_done", 64'(last_done), 64'h1);
    check("wr_nack", 64'(last_nack), 64'h0);
    check("wr_to", 64'(last_to), 64'h0);

    // read with master ACK/NACK sequence
    new_txn();
    rd_q = '{8'h11, 8'h22, 8'h33};
    arm(1, 7'h48, 1'b1, 4'd3);
    req_valid[1] = 1'b1;
    wait_done("rd", 1);
    exp_q = '{12'h100, 12'h291, 12'h301, 12'h301, 12'h300, 12'h400};
    check_log("rd");
    check("rd_nvalid", 64'(rv_q.size()), 64'd3);
    for (int k = 0; k < 3 && k < rv_q.size(); k++) begin
      check($sformatf("rd_data%0d", k), 64'(rv_q[k]), 64'(8'h11 * (k + 1)));
      check($sformatf("rd_who%0d", k), 64'(rv_who[k]), 64'd1);
    end
    check("rd_done", 64'(last_done), 64'h2);

    // address NACK
    new_txn();
    nack_addr = 1;
    arm(2, 7'h20, 1'b0, 4'd2);
    req_valid[2] = 1'b1;
    wait_done("nk", 1);
    nack_addr = 0;
    exp_q = '{12'h100, 12'h240, 12'h400};
    check_log("nk");
    check("nk_done", 64'(last_done), 64'h4);
    check("nk_nack", 64'(last_nack), 64'h4);
    check("nk_wack", 64'(wack_cnt[2]), 64'd0);

    // arbitration from a fresh pointer, req0 re-requests after its done
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    new_txn();
    for (int i = 0; i < 4; i++) arm(i, 7'(7'h10 + i), 1'b0, 4'd1);
    rearm0    = 1;
    multi_cnt = 0;
    req_valid = 4'hF;
    wait_done("arb", 5);
    check("arb_order", 64'(grant_seq), 64'h01230);
    check("arb_ngrant", 64'(grant_n), 64'd5);
    check("arb_onehot", 64'(multi_cnt), 64'd0);

    // timeout on START, then STOP completes
    new_txn();
    mute_start = 1;
    arm(3, 7'h2C, 1'b0, 4'd0);
    req_valid[3] = 1'b1;
    wait_done("to", 1);
    mute_start = 0;
    exp_q = '{12'h100, 12'h400};
    check_log("to");
    if (log_cyc.size() >= 2)
      check("to_stop_cycle", 64'(log_cyc[1] - log_cyc[0]), 64'd16);
    check("to_done", 64'(last_done), 64'h8);
    check("to_flag", 64'(last_to), 64'h8);
    check("to_nack", 64'(last_nack), 64'h0);

    // address-only probe
    new_txn();
    arm(2, 7'h3A, 1'b0, 4'd0);
    req_valid[2] = 1'b1;
    wait_done("probe", 1);
    exp_q = '{12'h100, 12'h274, 12'h400};
    check_log("probe");
    check("probe_flags", 64'({last_done, last_nack, last_to}), 64'h400);

    // reset in the middle of the data phase
    new_txn();
    arm(0, 7'h10, 1'b0, 4'd4);
    req_valid[0] = 1'b1;
    begin
      int k;
      k = 0;
      while (wack_cnt[0] == 0 && k < 50) begin
        tick();
        k++;
      end
    end
    check("rst_mid_reached", 64'(wack_cnt[0]), 64'd1);
    reset    = 1'b1;
    eng_wait = 0;
    eng_done = 1'b0;
    tick();
    check("rst_mid_outs", 64'(outs), 64'd0);
    reset = 1'b0;
    new_txn();
    arm(0, 7'h11, 1'b0, 4'd1);
    arm(1, 7'h12, 1'b0, 4'd1);
    req_valid = 4'b0011;
    tick();
    check("rst_ptr_grant", 64'(grant), 64'h1);
    wait_done("rst_after", 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
